data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 43 ++++
 rtl/load_store_align.sv | 101 ++++++++++
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data memory responder:
//   - state_e : responder FSM states (IDLE, WAIT, RESP)
//   - LB/LH/LW/LBU/LHU : RISC-V load funct3 codes
//   - SB/SH/SW         : RISC-V store funct3 codes
//   - funct3_legal()   : whether a funct3 code is defined for a load or store
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Load size/sign codes
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store size codes
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Stores only define the three sized codes; loads add the unsigned
    // byte/halfword variants.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end else begin
            ok = (funct3 == LB)  || (funct3 == LH)  || (funct3 == LW) ||
                 (funct3 == LBU) || (funct3 == LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// ---------------------------------------------------------------------------
// load_store_align
// Purely combinational lane logic for one memory access.
//   we, funct3, addr, wdata : the access being committed
//   mem_word                : current contents of the addressed 32-bit word
//   byte_en                 : per-byte write enables (all zero on loads/errors)
//   store_word              : store data replicated onto the addressed lanes
//   load_data               : extended load result (zero on stores/errors)
//   err                     : illegal funct3, misalignment or out-of-range index
// ---------------------------------------------------------------------------
module load_store_align
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        err
);

    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    logic        legal;
    logic        misaligned;
    logic        out_of_range;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Error classification
    always_comb begin
        legal = funct3_legal(we, funct3);
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, addr[31:2]} >= DEPTH_L);
        err          = !legal || misaligned || out_of_range;
    end

    // Little-endian lane selection for loads
    always_comb begin
        case (addr[1:0])
            2'd0:    sel_byte = mem_word[7:0];
            2'd1:    sel_byte = mem_word[15:8];
            2'd2:    sel_byte = mem_word[23:16];
            default: sel_byte = mem_word[31:24];
        endcase
        sel_half = addr[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Load extension; stores and rejected accesses return zero
    always_comb begin
        load_data = '0;
        if (!we && !err) begin
            case (funct3)
                LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
                LH:      load_data = {{16{sel_half[15]}}, sel_half};
                LW:      load_data = mem_word;
                LBU:     load_data = {24'd0, sel_byte};
                LHU:     load_data = {16'd0, sel_half};
                default: load_data = '0;
            endcase
        end
    end

    // Store lane enables; data is replicated so every lane carries the
    // right bytes and only the enables decide what lands in the array.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = '0;
        case (funct3)
            SB: begin
                byte_en    = 4'b0001 << addr[1:0];
                store_word = {4{wdata[7:0]}};
            end
            SH: begin
                byte_en    = addr[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata[15:0]}};
            end
            SW: begin
                byte_en    = 4'b1111;
                store_word = wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                store_word = '0;
            end
        endcase
        if (!we || err) begin
            byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data memory with a valid/ready request channel and a
// valid/ready response channel. A request is accepted in IDLE, waits LATENCY
// cycles in WAIT, and is committed (store) or sampled (load) on the edge that
// enters RESP, where the response is held until the core takes it.
//   clk, reset                     : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                      : request fields (RISC-V load/store style)
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata, rsp_err             : registered load data and error flag
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_e        state;
    logic [CW-1:0] cnt;

    logic          lat_we;
    logic [2:0]    lat_funct3;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;

    logic          handshake;
    logic          go_resp;

    logic          cur_we;
    logic [2:0]    cur_funct3;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;

    logic [31:0]   mem_word;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   load_data;
    logic          acc_err;

    // Not reset: contents survive a reset pulse.
    logic [31:0]   mem [DEPTH_WORDS];

    assign req_ready = (state == IDLE) && reset;
    assign handshake = req_valid && req_ready;

    // With zero latency the commit happens on the accepting edge itself, so
    // the live request fields feed the lane logic; otherwise the latched copy.
    assign go_resp = (LATENCY == 0) ? handshake : ((state == WAIT) && (cnt == '0));

    assign cur_we     = (state == IDLE) ? req_we     : lat_we;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
    assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

    assign mem_word = mem[cur_addr[AW+1:2]];

    load_store_align #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_align (
        .we         (cur_we),
        .funct3     (cur_funct3),
        .addr       (cur_addr),
        .wdata      (cur_wdata),
        .mem_word   (mem_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .err        (acc_err)
    );

    // Control: FSM, wait counter and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (go_resp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= load_data;
                rsp_err   <= acc_err;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (handshake) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    // Array write on entry to RESP; byte_en is already zero for loads and
    // rejected accesses, so an out-of-range index never writes.
    always_ff @(posedge clk) begin
        if (go_resp) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[cur_addr[AW+1:2]][8*b +: 8] <= store_word[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic        clk;
    logic [1:0]  reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata  [2];
    logic [1:0]  rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Instance 0: LATENCY=2, instance 1: LATENCY=0
    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     ((g == 0) ? 2 : 0)
        ) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    // Byte-addressed memory image, one per instance.
    logic [7:0] mmem [2][DEPTH*4];

    function automatic void model_eval(input int i, input logic we, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
        logic legal;
        int   sz;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        rd    = '0;
        er    = 1'b0;
        if (!legal) er = 1'b1;
        else if ((a % sz) != 0) er = 1'b1;
        else if ((a >> 2) >= 32'(DEPTH)) er = 1'b1;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < sz; b++) mmem[i][int'(a) + b] = wd[8*b +: 8];
            end else begin
                v = '0;
                for (int b = 0; b < sz; b++) v[8*b +: 8] = mmem[i][int'(a) + b];
                if (!f3[2] && sz < 4 && v[8*sz-1]) begin
                    for (int b = 8*sz; b < 32; b++) v[b] = 1'b1;
                end
                rd = v;
            end
        end
    endfunction

    // Model state per instance
    logic [1:0]  pend, done;
    int          hs_cyc [2];
    logic        t_we   [2];
    logic [2:0]  t_f3   [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wd   [2];
    logic [31:0] exp_rd [2];
    logic        exp_er [2];
    logic        exp_v;

    initial begin
        pend = '0;
        done = '0;
    end

    // Compare process: every cycle, both instances
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset[i]) begin
                pend[i] = 1'b0;
                chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
                chk("rst_req_ready", i, 32'(req_ready[i]), 32'd0);
                chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
                chk("rst_rsp_err",   i, 32'(rsp_err[i]), 32'd0);
            end else begin
                exp_v = pend[i] && ((cyc - hs_cyc[i]) >= lat_of(i) + 1);
                if (exp_v && !done[i]) begin
                    model_eval(i, t_we[i], t_f3[i], t_addr[i], t_wd[i], exp_rd[i], exp_er[i]);
                    done[i] = 1'b1;
                end
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(exp_v));
                chk("req_ready", i, 32'(req_ready[i]), 32'(!pend[i]));
                if (exp_v) begin
                    chk("rsp_rdata", i, rsp_rdata[i], exp_rd[i]);
                    chk("rsp_err",   i, 32'(rsp_err[i]), 32'(exp_er[i]));
                end
                if (exp_v && rsp_ready[i]) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && req_valid[i]) begin
                    pend[i]   = 1'b1;
                    done[i]   = 1'b0;
                    hs_cyc[i] = cyc;
                    t_we[i]   = req_we[i];
                    t_f3[i]   = req_funct3[i];
                    t_addr[i] = req_addr[i];
                    t_wd[i]   = req_wdata[i];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic xact(input int i, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int stall, input logic early,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = '0; er = 1'b0; lat = 0;
        req_we[i] = we; req_funct3[i] = f3; req_addr[i] = a; req_wdata[i] = wd;
        req_valid[i] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[i] && n < 20);
        if (!req_ready[i]) begin
            chk("req_ready_timeout", i, 32'd0, 32'd1);
            req_valid[i] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        if (early) rsp_ready[i] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[i] && n < 20);
        lat = n;
        if (!rsp_valid[i]) begin
            chk("rsp_valid_timeout", i, 32'd0, 32'd1);
            rsp_ready[i] = 1'b0;
            return;
        end
        rd = rsp_rdata[i];
        er = rsp_err[i];
        if (!early) begin
            repeat (stall) @(negedge clk);
            @(posedge clk); #1;
            rsp_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready[i] = 1'b0;
    endtask

    // Directed access with hand-computed expectations for DUT and model
    task automatic dx(input string nm, input int i, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int stall,
                      input logic [31:0] want_rd, input logic want_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(i, we, f3, a, wd, stall, 1'b0, rd, er, lat);
        chk({nm, "_rdata"}, i, rd, want_rd);
        chk({nm, "_err"},   i, 32'(er), 32'(want_er));
        chk({nm, "_lat"},   i, 32'(lat), 32'(lat_of(i) + 1));
        chk({nm, "_model_rdata"}, i, exp_rd[i], want_rd);
        chk({nm, "_model_err"},   i, 32'(exp_er[i]), 32'(want_er));
    endtask

    initial begin
        logic [31:0] rd, prior;
        logic        er;
        int          lat;
        logic [2:0]  f3;
        logic [2:0]  legal_f3 [5];
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
        legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

        reset = 2'b11;
        req_valid = '0; req_we = '0; rsp_ready = '0;
        for (int i = 0; i < 2; i++) begin
            req_funct3[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
        end
        #1 reset = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 2'b11;
        @(negedge clk);
        chk("idle_req_ready", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;

        // Fill both arrays so every in-range load has a known value
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < DEPTH; w++) begin
                xact(i, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, 1'b0, rd, er, lat);
            end
        end

        // Basic store/load and extension cases, LATENCY=2
        dx("sw_10",   0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        dx("lw_10",   0, 1'b0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0);
        dx("lb_13",   0, 1'b0, 3'b000, 32'h13, 32'h0,        0, 32'hFFFFFFDE, 1'b0);
        dx("lbu_13",  0, 1'b0, 3'b100, 32'h13, 32'h0,        0, 32'h000000DE, 1'b0);
        dx("lh_12",   0, 1'b0, 3'b001, 32'h12, 32'h0,        0, 32'hFFFFDEAD, 1'b0);
        dx("lhu_10",  0, 1'b0, 3'b101, 32'h10, 32'h0,        0, 32'h0000BEEF, 1'b0);
        dx("sb_11",   0, 1'b1, 3'b000, 32'h11, 32'h00000055, 0, 32'h0, 1'b0);
        dx("lw_sb",   0, 1'b0, 3'b010, 32'h10, 32'h0,        0, 32'hDEAD55EF, 1'b0);
        dx("sh_12",   0, 1'b1, 3'b001, 32'h12, 32'hAAAA1234, 0, 32'h0, 1'b0);
        dx("lw_sh",   0, 1'b0, 3'b010, 32'h10, 32'h0,        0, 32'h123455EF, 1'b0);
        // Errors leave the array alone
        dx("sw_mis",  0, 1'b1, 3'b010, 32'h12, 32'h11111111, 0, 32'h0, 1'b1);
        dx("lw_keep", 0, 1'b0, 3'b010, 32'h10, 32'h0,        0, 32'h123455EF, 1'b0);
        dx("lw_oor",  0, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 0, 32'h0, 1'b1);
        dx("ld_f3_3", 0, 1'b0, 3'b011, 32'h10, 32'h0,        0, 32'h0, 1'b1);
        dx("sb_f3_4", 0, 1'b1, 3'b100, 32'h10, 32'h0,        0, 32'h0, 1'b1);
        dx("lh_odd",  0, 1'b0, 3'b001, 32'h11, 32'h0,        0, 32'h0, 1'b1);
        // Back-pressure: response held for several cycles
        dx("lw_stall", 0, 1'b0, 3'b010, 32'h10, 32'h0,       5, 32'h123455EF, 1'b0);
        @(negedge clk);
        chk("after_release_req_ready", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;

        // Reset pulse during WAIT discards the store
        xact(0, 1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, prior, er, lat);
        req_we[0] = 1'b1; req_funct3[0] = 3'b010; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h12345678; req_valid[0] = 1'b1;
        @(negedge clk);
        chk("rst_hs_ready", 0, 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #2 reset[0] = 1'b0;
        @(negedge clk);
        chk("rst_wait_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        reset[0] = 1'b1;
        @(posedge clk); #1;
        dx("lw_after_rst", 0, 1'b0, 3'b010, 32'h20, 32'h0, 0, prior, 1'b0);

        // LATENCY=0 instance
        dx("l0_sw", 1, 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 0, 32'h0, 1'b0);
        dx("l0_lw", 1, 1'b0, 3'b010, 32'h4, 32'h0,        0, 32'hCAFEF00D, 1'b0);
        dx("l0_lh", 1, 1'b0, 3'b001, 32'h6, 32'h0,        2, 32'hFFFFCAFE, 1'b0);

        // Randomized traffic on both instances
        for (int k = 0; k < 600; k++) begin
            int i;
            i  = k % 2;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            xact(i, 1'($urandom), f3, 32'($urandom_range(0, DEPTH * 4 + 31)), $urandom,
                 $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0), rd, er, lat);
            chk("rand_lat", i, 32'(lat), 32'(lat_of(i) + 1));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
